// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a fixed {note, beats} song ROM and presents the
// tone generator's half-period reload, tone enable and note strobe, with a
// short silent gap closing every note.
module melody_sequencer #(
    parameter int unsigned BEAT_TICKS = 4_000_000,
    parameter int unsigned GAP_TICKS  = 160_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        play_i,
    input  logic        stop_i,
    input  logic        loop_i,
    output logic [14:0] half_period_o,
    output logic        tone_en_o,
    output logic [3:0]  note_idx_o,
    output logic        note_strobe_o,
    output logic        busy_o
);

    localparam int unsigned       TICK_W      = $clog2(BEAT_TICKS);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(BEAT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_GAP    = TICK_W'(GAP_TICKS);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SOUND,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [14:0]       half_period_q, half_period_d;
    logic              tone_en_q, tone_en_d;
    logic [3:0]        note_idx_q, note_idx_d;
    logic              note_strobe_q, note_strobe_d;

    logic [7:0]        rom_entry;
    logic [3:0]        rom_note;
    logic [3:0]        rom_beats;
    logic [14:0]       rom_hp;

    // Half-period reload in 16 MHz clocks for each note code; anything else is a rest.
    function automatic logic [14:0] note_hp(input logic [3:0] note);
        case (note)
            4'd1:    return 15'd30578;
            4'd2:    return 15'd27242;
            4'd3:    return 15'd24270;
            4'd4:    return 15'd22908;
            4'd5:    return 15'd20408;
            4'd6:    return 15'd18182;
            4'd7:    return 15'd16198;
            4'd8:    return 15'd15289;
            default: return 15'd0;
        endcase
    endfunction

    // Song ROM: {note, beats}; beats = 0 marks the end of the song.
    always_comb begin
        case (ptr_q)
            3'd0:    rom_entry = {4'd1, 4'd1};
            3'd1:    rom_entry = {4'd1, 4'd1};
            3'd2:    rom_entry = {4'd5, 4'd1};
            3'd3:    rom_entry = {4'd5, 4'd1};
            3'd4:    rom_entry = {4'd6, 4'd1};
            3'd5:    rom_entry = {4'd6, 4'd1};
            3'd6:    rom_entry = {4'd5, 4'd2};
            default: rom_entry = 8'h00;
        endcase
    end

    assign rom_note  = rom_entry[7:4];
    assign rom_beats = rom_entry[3:0];
    assign rom_hp    = note_hp(rom_note);

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        beat_cnt_d    = beat_cnt_q;
        tick_cnt_d    = tick_cnt_q;
        half_period_d = half_period_q;
        tone_en_d     = tone_en_q;
        note_idx_d    = note_idx_q;
        note_strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (play_i && !stop_i) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                end
            end
            FETCH: begin
                if (rom_beats == 4'd0) begin
                    if (loop_i) begin
                        ptr_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d       = SOUND;
                    beat_cnt_d    = rom_beats;
                    tick_cnt_d    = TICK_RELOAD;
                    half_period_d = rom_hp;
                    note_idx_d    = rom_note;
                    tone_en_d     = (rom_hp != 15'd0);
                    note_strobe_d = 1'b1;
                end
            end
            SOUND: begin
                if (beat_cnt_q == 4'd1 && tick_cnt_q == TICK_GAP) begin
                    state_d    = GAP;
                    tone_en_d  = 1'b0;
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end else if (tick_cnt_q == '0) begin
                    tick_cnt_d = TICK_RELOAD;
                    beat_cnt_d = beat_cnt_q - 4'd1;
                end else begin
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end
            end
            GAP: begin
                if (tick_cnt_q == '0) begin
                    state_d = FETCH;
                    ptr_d   = ptr_q + 3'd1;
                end else begin
                    tick_cnt_d = tick_cnt_q - TICK_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // STOP aborts from any active state.
        if (state_q != IDLE && stop_i) begin
            state_d = IDLE;
            ptr_d   = '0;
        end

        // Everything the tone generator sees is silent while idle.
        if (state_d == IDLE) begin
            half_period_d = '0;
            tone_en_d     = 1'b0;
            note_idx_d    = '0;
            note_strobe_d = 1'b0;
        end
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            beat_cnt_q    <= '0;
            tick_cnt_q    <= '0;
            half_period_q <= '0;
            tone_en_q     <= 1'b0;
            note_idx_q    <= '0;
            note_strobe_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            half_period_q <= half_period_d;
            tone_en_q     <= tone_en_d;
            note_idx_q    <= note_idx_d;
            note_strobe_q <= note_strobe_d;
        end
    end

    assign half_period_o = half_period_q;
    assign tone_en_o     = tone_en_q;
    assign note_idx_o    = note_idx_q;
    assign note_strobe_o = note_strobe_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with short beats (20 clocks) and gaps (4 clocks).
module tb_melody_sequencer;

    localparam int BT = 20;
    localparam int GT = 4;
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic        stop;
    logic        loop;
    logic [14:0] half_period;
    logic        tone_en;
    logic [3:0]  note_idx;
    logic        note_strobe;
    logic        busy;

    int errors = 0;
    int checks = 0;

    melody_sequencer #(
        .BEAT_TICKS(BT),
        .GAP_TICKS (GT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .play_i       (play),
        .stop_i       (stop),
        .loop_i       (loop),
        .half_period_o(half_period),
        .tone_en_o    (tone_en),
        .note_idx_o   (note_idx),
        .note_strobe_o(note_strobe),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // The song as written: notes and beat counts, beats 0 = end marker.
    int song_note  [0:7] = '{1, 1, 5, 5, 6, 6, 5, 0};
    int song_beats [0:7] = '{1, 1, 1, 1, 1, 1, 2, 0};

    function automatic int hp_of(input int n);
        case (n)
            1:       return 30578;
            2:       return 27242;
            3:       return 24270;
            4:       return 22908;
            5:       return 20408;
            6:       return 18182;
            7:       return 16198;
            8:       return 15289;
            default: return 0;
        endcase
    endfunction

    // Reference model: song position as (entry, cycle within entry);
    // cycle 0 is the fetch, cycles 1..beats*BT are audible except the last GT.
    bit m_play;
    int m_e;
    int m_k;
    int m_hp;
    int m_note;
    bit m_tone;
    bit m_strobe;

    task automatic model_reset();
        m_play = 1'b0; m_e = 0; m_k = 0;
        m_hp = 0; m_note = 0; m_tone = 1'b0; m_strobe = 1'b0;
    endtask

    task automatic model_step(input bit p, input bit s, input bit l);
        if (!m_play) begin
            if (p && !s) begin
                m_play = 1'b1; m_e = 0; m_k = 0;
            end
        end else if (s) begin
            m_play = 1'b0;
        end else if (m_k == 0) begin
            if (song_beats[m_e] == 0) begin
                if (l) m_e = 0;
                else   m_play = 1'b0;
            end else begin
                m_k = 1;
            end
        end else if (m_k == song_beats[m_e] * BT) begin
            m_e = m_e + 1;
            m_k = 0;
        end else begin
            m_k = m_k + 1;
        end

        m_strobe = m_play && (m_k == 1);
        if (!m_play) begin
            m_hp = 0; m_note = 0; m_tone = 1'b0;
        end else if (m_k == 0) begin
            m_tone = 1'b0;
        end else begin
            m_note = song_note[m_e];
            m_hp   = hp_of(m_note);
            m_tone = (m_k <= song_beats[m_e] * BT - GT) && (m_hp != 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs while clk is low, advance model at the edge, compare at negedge.
    task automatic step(input bit p, input bit s, input bit l);
        play = p; stop = s; loop = l;
        @(posedge clk);
        model_step(p, s, l);
        @(negedge clk);
        chk("model.half_period", int'(half_period), m_hp);
        chk("model.tone_en",     int'(tone_en),     int'(m_tone));
        chk("model.note_idx",    int'(note_idx),    m_note);
        chk("model.note_strobe", int'(note_strobe), int'(m_strobe));
        chk("model.busy",        int'(busy),        int'(m_play));
    endtask

    typedef struct {
        bit p; bit s; bit l; int reps;
        int hp; int tone; int note; int strb; int busy;
    } vec_t;

    vec_t vecs [0:NV-1];

    initial begin
        int busy_cnt, strobes, run, first_run, last_run, bad_tone, bad_strb, drop;
        int eighth_c, eighth_hp;
        int exp_seq [0:6];
        int hp_seq [$];
        bit prev_strb, done, lp;

        exp_seq = '{30578, 30578, 20408, 20408, 18182, 18182, 20408};

        //           p  s  l  reps  hp     tone note strb busy
        vecs[0]  = '{0, 0, 0, 2,    0,     0,   0,   0,   0};  // idle
        vecs[1]  = '{1, 1, 0, 1,    0,     0,   0,   0,   0};  // PLAY+STOP in idle
        vecs[2]  = '{1, 0, 0, 1,    0,     0,   0,   0,   1};  // fetch
        vecs[3]  = '{0, 0, 0, 1,    30578, 1,   1,   1,   1};  // first sound cycle
        vecs[4]  = '{0, 0, 0, 15,   30578, 1,   1,   0,   1};  // last audible cycle
        vecs[5]  = '{0, 0, 0, 1,    30578, 0,   1,   0,   1};  // gap starts
        vecs[6]  = '{0, 0, 0, 3,    30578, 0,   1,   0,   1};  // end of gap
        vecs[7]  = '{0, 0, 0, 1,    30578, 0,   1,   0,   1};  // fetch entry 1
        vecs[8]  = '{1, 0, 0, 1,    30578, 1,   1,   1,   1};  // PLAY while busy ignored
        vecs[9]  = '{1, 0, 0, 5,    30578, 1,   1,   0,   1};
        vecs[10] = '{0, 0, 0, 14,   30578, 0,   1,   0,   1};
        vecs[11] = '{0, 0, 0, 1,    30578, 0,   1,   0,   1};  // fetch entry 2
        vecs[12] = '{0, 0, 0, 1,    20408, 1,   5,   1,   1};  // G4
        vecs[13] = '{0, 0, 0, 9,    20408, 1,   5,   0,   1};  // cycle 10 of note 3
        vecs[14] = '{0, 1, 0, 1,    0,     0,   0,   0,   0};  // STOP
        vecs[15] = '{1, 0, 0, 1,    0,     0,   0,   0,   1};  // restart
        vecs[16] = '{0, 0, 0, 1,    30578, 1,   1,   1,   1};  // back at C4
        vecs[17] = '{0, 1, 0, 1,    0,     0,   0,   0,   0};

        // Reset state
        rst = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset.half_period", int'(half_period), 0);
        chk("reset.tone_en",     int'(tone_en),     0);
        chk("reset.note_idx",    int'(note_idx),    0);
        chk("reset.note_strobe", int'(note_strobe), 0);
        chk("reset.busy",        int'(busy),        0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].p, vecs[i].s, vecs[i].l);
            chk($sformatf("vec%0d.half_period", i), int'(half_period), vecs[i].hp);
            chk($sformatf("vec%0d.tone_en", i),     int'(tone_en),     vecs[i].tone);
            chk($sformatf("vec%0d.note_idx", i),    int'(note_idx),    vecs[i].note);
            chk($sformatf("vec%0d.note_strobe", i), int'(note_strobe), vecs[i].strb);
            chk($sformatf("vec%0d.busy", i),        int'(busy),        vecs[i].busy);
        end

        // Full song, LOOP=0
        busy_cnt = 0; strobes = 0; run = 0; first_run = -1; last_run = -1;
        bad_tone = 0; bad_strb = 0; prev_strb = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            step(c == 0, 1'b0, 1'b0);
            if (busy) busy_cnt++;
            else done = 1'b1;
            if (note_strobe) begin
                strobes++;
                hp_seq.push_back(int'(half_period));
                if (prev_strb) bad_strb++;
            end
            prev_strb = note_strobe;
            if (tone_en && half_period == 15'd0) bad_tone++;
            if (tone_en) begin
                run++;
            end else begin
                if (run > 0) begin
                    if (first_run < 0) first_run = run;
                    last_run = run;
                end
                run = 0;
            end
        end
        chk("song.finished",     int'(done), 1);
        chk("song.busy_cycles",  busy_cnt, 168);
        chk("song.strobes",      strobes, 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("song.hp%0d", i), (i < hp_seq.size()) ? hp_seq[i] : -1, exp_seq[i]);
        chk("song.first_tone_run", first_run, 16);
        chk("song.last_tone_run",  last_run, 36);
        chk("song.tone_with_hp0",  bad_tone, 0);
        chk("song.strobe_width",   bad_strb, 0);

        // LOOP=1: song restarts without BUSY dropping
        strobes = 0; drop = 0; eighth_c = -1; eighth_hp = -1;
        for (int c = 0; c < 350; c++) begin
            step(c == 0, 1'b0, 1'b1);
            if (!busy) drop++;
            if (note_strobe) begin
                strobes++;
                if (strobes == 8) begin
                    eighth_c  = c;
                    eighth_hp = int'(half_period);
                end
            end
        end
        chk("loop.busy_drops",  drop, 0);
        chk("loop.restart_cyc", eighth_c, 169);
        chk("loop.restart_hp",  eighth_hp, 30578);
        step(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-note
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("areset.half_period", int'(half_period), 0);
        chk("areset.tone_en",     int'(tone_en),     0);
        chk("areset.note_idx",    int'(note_idx),    0);
        chk("areset.busy",        int'(busy),        0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random stimulus against the model
        lp = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) lp = ~lp;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0, lp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
